// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module      : nibble_serial_adder
// Description : WIDTH-bit adder that reuses one 4-bit ripple-carry slice over
//               WIDTH/4 cycles, with valid/ready handshakes on both sides.
//               Optional signed-overflow output enabled by OVF_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVF_DETECT_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [3:0]        slice_sum;
    logic              slice_cout;
    logic              accept;
    logic              last_nib;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign last_nib  = (idx == LAST_IDX);

    // Operand nibble select; idx never exceeds NIB-1 so the default is unused.
    always_comb begin
        a_nib = 4'd0;
        b_nib = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    rca4 u_rca4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = BUSY;
            BUSY: if (last_nib)  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            idx     <= '0;
        end else if (state == BUSY) begin
            for (int i = 0; i < NIB; i++) begin
                if (idx == IDXW'(i)) begin
                    sum_q[4*i +: 4] <= slice_sum;
                end
            end
            carry_q <= slice_cout;
            if (!last_nib) begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    // Results are only exposed in DONE so partial sums never leak out.
    assign sum  = out_valid ? sum_q   : '0;
    assign cout = out_valid ? carry_q : 1'b0;

`ifdef OVF_DETECT_EN
    logic ovf_q;

    // Evaluated on the MSB nibble, so slice_sum[3] is the final sum MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state == BUSY) && last_nib) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
        end
    end

    assign ovf = out_valid ? ovf_q : 1'b0;
`endif

endmodule

`default_nettype wire
